// File: rtl/pa_fpu_fmau_issue_ctrl.sv
// -----------------------------------------------------------------------------
// pa_fpu_fmau_issue_ctrl
//
// Issue / pipeline control for the FPU fused multiply-add unit (FMAU).
// The FMAU datapath keeps its own copies of the EX2..EX4 valid bits. This block
// keeps mirror copies of them, updated with exactly the same rules, and uses
// them to produce:
//   - the EX1 issue select towards the FMAU,
//   - the per-stage stall and EX2 cancel signals,
//   - arbitration of the single FPU write-back port between EX4, EX3 and EX2,
//   - the EX1 completion and debug-busy indications towards RTU/HAD.
//
// Ports
//   forever_cpuclk            free-running core clock
//   cpurst_b                  asynchronous active-low reset
//   cp0_fpu_icg_en            clock-gate module enable (1 = keep clock running)
//   cp0_yy_clk_en             clock-gate global enable
//   pad_yy_icg_scan_en        clock-gate scan override
//   idu_fpu_ex1_inst_vld      EX1 instruction valid
//   idu_fpu_ex1_gateclk_vld   EX1 valid used only for clock gating
//   idu_fpu_ex1_inst_vld_dp   duplicated EX1 valid (timing copy)
//   idu_fpu_ex1_eu_sel[2:0]   execution-unit one-hot, bit 1 selects the FMAU
//   rtu_xx_ex1_cancel         kill the instruction in EX1
//   rtu_fpu_ex2_cancel        flush the instruction in EX2
//   rtu_fpu_wb_stall          write-back port busy this cycle
//   fmau_fpu_ex1_cmplt        FMAU reports EX1 completion
//   fmau_fpu_ex1_denorm_stall FMAU holds EX1 one cycle for a denormal operand
//   fmau_fpu_id_reg_set       FMAU re-issue cycle after a denormal hold
//   fmau_fpu_ex2_special_cmplt EX2 result produced early (special operands)
//   fmau_fpu_ex3_result_vld   EX3 result ready (non-accumulating op)
//   ctrl_fmau_ex1_sel         FMAU issue select
//   ctrl_fmau_ex1_sel_gate    FMAU issue select for clock gating
//   ctrl_xx_ex1_cmplt_dp      duplicated completion qualifier
//   ctrl_xx_ex1..4_stall      per-stage stall to the FMAU
//   ctrl_xx_ex2_cancel        EX2 flush to the FMAU
//   fpu_idu_ex1_stall         EX1 stall back to the issue unit
//   fpu_rtu_ex1_cmplt         EX1 completion to retire unit
//   fpu_rtu_wb_vld            write-back valid
//   fpu_rtu_wb_src[2:0]       write-back source one-hot {EX4,EX3,EX2}
//   fpu_had_busy              any FMAU instruction still in flight
// -----------------------------------------------------------------------------
module pa_fpu_fmau_issue_ctrl (
    input  logic       forever_cpuclk,
    input  logic       cpurst_b,
    input  logic       cp0_fpu_icg_en,
    input  logic       cp0_yy_clk_en,
    input  logic       pad_yy_icg_scan_en,
    input  logic       idu_fpu_ex1_inst_vld,
    input  logic       idu_fpu_ex1_gateclk_vld,
    input  logic       idu_fpu_ex1_inst_vld_dp,
    input  logic [2:0] idu_fpu_ex1_eu_sel,
    input  logic       rtu_xx_ex1_cancel,
    input  logic       rtu_fpu_ex2_cancel,
    input  logic       rtu_fpu_wb_stall,
    input  logic       fmau_fpu_ex1_cmplt,
    input  logic       fmau_fpu_ex1_denorm_stall,
    input  logic       fmau_fpu_id_reg_set,
    input  logic       fmau_fpu_ex2_special_cmplt,
    input  logic       fmau_fpu_ex3_result_vld,
    output logic       ctrl_fmau_ex1_sel,
    output logic       ctrl_fmau_ex1_sel_gate,
    output logic       ctrl_xx_ex1_cmplt_dp,
    output logic       ctrl_xx_ex1_stall,
    output logic       ctrl_xx_ex2_stall,
    output logic       ctrl_xx_ex3_stall,
    output logic       ctrl_xx_ex4_stall,
    output logic       ctrl_xx_ex2_cancel,
    output logic       fpu_idu_ex1_stall,
    output logic       fpu_rtu_ex1_cmplt,
    output logic       fpu_rtu_wb_vld,
    output logic [2:0] fpu_rtu_wb_src,
    output logic       fpu_had_busy
);

    // Mirror copies of the FMAU stage valids.
    logic r_ex2_vld;
    logic r_ex3_vld;
    logic r_ex4_vld;

    logic w_ex3_mac;
    logic w_wb4_req;
    logic w_wb3_req;
    logic w_wb2_req;
    logic w_wb_any;
    logic w_ex2_local_en;
    logic w_ex3_local_en;
    logic w_ex4_local_en;
    logic w_ex2_clk_en;
    logic w_ex3_clk_en;
    logic w_ex4_clk_en;

    // -------------------------------------------------------------------------
    // EX1 issue select
    // -------------------------------------------------------------------------
    assign ctrl_fmau_ex1_sel      = idu_fpu_ex1_inst_vld    & idu_fpu_ex1_eu_sel[1];
    assign ctrl_fmau_ex1_sel_gate = idu_fpu_ex1_gateclk_vld & idu_fpu_ex1_eu_sel[1];
    assign ctrl_xx_ex1_cmplt_dp   = idu_fpu_ex1_inst_vld_dp;

    // -------------------------------------------------------------------------
    // Write-back arbitration
    // -------------------------------------------------------------------------
    // An instruction still valid in EX3 without a result is an accumulating
    // (mac) op that must continue to EX4.
    assign w_ex3_mac = r_ex3_vld & ~fmau_fpu_ex3_result_vld;

    assign w_wb4_req = r_ex4_vld;
    assign w_wb3_req = fmau_fpu_ex3_result_vld;
    assign w_wb2_req = r_ex2_vld & fmau_fpu_ex2_special_cmplt & ~rtu_fpu_ex2_cancel;
    assign w_wb_any  = w_wb4_req | w_wb3_req | w_wb2_req;

    assign fpu_rtu_wb_vld = w_wb_any & ~rtu_fpu_wb_stall;

    // Fixed priority: the oldest instruction (deepest stage) wins the port.
    always_comb begin
        fpu_rtu_wb_src = 3'b000;
        if (fpu_rtu_wb_vld) begin
            if (w_wb4_req) begin
                fpu_rtu_wb_src = 3'b100;
            end else if (w_wb3_req) begin
                fpu_rtu_wb_src = 3'b010;
            end else begin
                fpu_rtu_wb_src = 3'b001;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stall cascade, EX4 back to EX1
    // -------------------------------------------------------------------------
    // A stage stalls when its own result loses the port, or when it has to
    // move forward into a stage that is itself stalled.
    assign ctrl_xx_ex4_stall = r_ex4_vld & rtu_fpu_wb_stall;

    assign ctrl_xx_ex3_stall = r_ex3_vld
                             & ((w_wb3_req & (rtu_fpu_wb_stall | w_wb4_req))
                              | (w_ex3_mac & ctrl_xx_ex4_stall));

    // A special result completes in EX2 and never enters EX3, so it does not
    // care about an EX3 stall.
    assign ctrl_xx_ex2_stall = r_ex2_vld
                             & ((w_wb2_req & (rtu_fpu_wb_stall | w_wb4_req | w_wb3_req))
                              | (~fmau_fpu_ex2_special_cmplt & ctrl_xx_ex3_stall));

    assign ctrl_xx_ex1_stall  = fmau_fpu_ex1_denorm_stall | ctrl_xx_ex2_stall;
    assign fpu_idu_ex1_stall  = ctrl_fmau_ex1_sel & ctrl_xx_ex1_stall;
    assign ctrl_xx_ex2_cancel = rtu_fpu_ex2_cancel & r_ex2_vld;
    assign fpu_rtu_ex1_cmplt  = fmau_fpu_ex1_cmplt & ~ctrl_xx_ex2_stall & ~rtu_xx_ex1_cancel;

    // fmau_fpu_id_reg_set covers the re-issue cycle after a denormal hold,
    // when no stage valid is set yet but the unit is still busy.
    assign fpu_had_busy = r_ex2_vld | r_ex3_vld | r_ex4_vld | fmau_fpu_id_reg_set;

    // -------------------------------------------------------------------------
    // Clock-gate enables
    // -------------------------------------------------------------------------
    // Same enable function as the gated clock cells feeding the FMAU stage
    // registers: a stage only clocks while something can enter or leave it,
    // unless the module gate is disabled or scan forces the clock on.
    assign w_ex2_local_en = ctrl_fmau_ex1_sel_gate | r_ex2_vld;
    assign w_ex3_local_en = r_ex2_vld | r_ex3_vld;
    assign w_ex4_local_en = r_ex3_vld | r_ex4_vld;

    assign w_ex2_clk_en = (cp0_yy_clk_en & (cp0_fpu_icg_en | w_ex2_local_en)) | pad_yy_icg_scan_en;
    assign w_ex3_clk_en = (cp0_yy_clk_en & (cp0_fpu_icg_en | w_ex3_local_en)) | pad_yy_icg_scan_en;
    assign w_ex4_clk_en = (cp0_yy_clk_en & (cp0_fpu_icg_en | w_ex4_local_en)) | pad_yy_icg_scan_en;

    // -------------------------------------------------------------------------
    // EX1 -> EX2
    // -------------------------------------------------------------------------
    // A flush wins over a stall: the instruction leaves EX2 even if held.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_ex2_vld <= 1'b0;
        end else if (w_ex2_clk_en) begin
            if (rtu_fpu_ex2_cancel) begin
                r_ex2_vld <= 1'b0;
            end else if (!ctrl_xx_ex2_stall) begin
                r_ex2_vld <= ctrl_fmau_ex1_sel & ~rtu_xx_ex1_cancel & ~ctrl_xx_ex1_stall;
            end
        end
    end

    // -------------------------------------------------------------------------
    // EX2 -> EX3
    // -------------------------------------------------------------------------
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_ex3_vld <= 1'b0;
        end else if (w_ex3_clk_en) begin
            if (!ctrl_xx_ex3_stall) begin
                r_ex3_vld <= r_ex2_vld & ~ctrl_xx_ex2_cancel
                           & ~fmau_fpu_ex2_special_cmplt & ~ctrl_xx_ex2_stall;
            end
        end
    end

    // -------------------------------------------------------------------------
    // EX3 -> EX4
    // -------------------------------------------------------------------------
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_ex4_vld <= 1'b0;
        end else if (w_ex4_clk_en) begin
            if (!ctrl_xx_ex4_stall) begin
                r_ex4_vld <= w_ex3_mac & ~ctrl_xx_ex3_stall;
            end
        end
    end

endmodule

// File: tb/tb_pa_fpu_fmau_issue_ctrl.sv
module tb_pa_fpu_fmau_issue_ctrl;

    logic       clk;
    logic       cpurst_b;
    logic       cp0_fpu_icg_en;
    logic       cp0_yy_clk_en;
    logic       pad_yy_icg_scan_en;
    logic       idu_fpu_ex1_inst_vld;
    logic       idu_fpu_ex1_gateclk_vld;
    logic       idu_fpu_ex1_inst_vld_dp;
    logic [2:0] idu_fpu_ex1_eu_sel;
    logic       rtu_xx_ex1_cancel;
    logic       rtu_fpu_ex2_cancel;
    logic       rtu_fpu_wb_stall;
    logic       fmau_fpu_ex1_cmplt;
    logic       fmau_fpu_ex1_denorm_stall;
    logic       fmau_fpu_id_reg_set;
    logic       fmau_fpu_ex2_special_cmplt;
    logic       fmau_fpu_ex3_result_vld;
    logic       ctrl_fmau_ex1_sel;
    logic       ctrl_fmau_ex1_sel_gate;
    logic       ctrl_xx_ex1_cmplt_dp;
    logic       ctrl_xx_ex1_stall;
    logic       ctrl_xx_ex2_stall;
    logic       ctrl_xx_ex3_stall;
    logic       ctrl_xx_ex4_stall;
    logic       ctrl_xx_ex2_cancel;
    logic       fpu_idu_ex1_stall;
    logic       fpu_rtu_ex1_cmplt;
    logic       fpu_rtu_wb_vld;
    logic [2:0] fpu_rtu_wb_src;
    logic       fpu_had_busy;

    int n_checks = 0;
    int n_errors = 0;
    bit run_cmp  = 1'b1;

    pa_fpu_fmau_issue_ctrl dut (
        .forever_cpuclk             (clk),
        .cpurst_b                   (cpurst_b),
        .cp0_fpu_icg_en             (cp0_fpu_icg_en),
        .cp0_yy_clk_en              (cp0_yy_clk_en),
        .pad_yy_icg_scan_en         (pad_yy_icg_scan_en),
        .idu_fpu_ex1_inst_vld       (idu_fpu_ex1_inst_vld),
        .idu_fpu_ex1_gateclk_vld    (idu_fpu_ex1_gateclk_vld),
        .idu_fpu_ex1_inst_vld_dp    (idu_fpu_ex1_inst_vld_dp),
        .idu_fpu_ex1_eu_sel         (idu_fpu_ex1_eu_sel),
        .rtu_xx_ex1_cancel          (rtu_xx_ex1_cancel),
        .rtu_fpu_ex2_cancel         (rtu_fpu_ex2_cancel),
        .rtu_fpu_wb_stall           (rtu_fpu_wb_stall),
        .fmau_fpu_ex1_cmplt         (fmau_fpu_ex1_cmplt),
        .fmau_fpu_ex1_denorm_stall  (fmau_fpu_ex1_denorm_stall),
        .fmau_fpu_id_reg_set        (fmau_fpu_id_reg_set),
        .fmau_fpu_ex2_special_cmplt (fmau_fpu_ex2_special_cmplt),
        .fmau_fpu_ex3_result_vld    (fmau_fpu_ex3_result_vld),
        .ctrl_fmau_ex1_sel          (ctrl_fmau_ex1_sel),
        .ctrl_fmau_ex1_sel_gate     (ctrl_fmau_ex1_sel_gate),
        .ctrl_xx_ex1_cmplt_dp       (ctrl_xx_ex1_cmplt_dp),
        .ctrl_xx_ex1_stall          (ctrl_xx_ex1_stall),
        .ctrl_xx_ex2_stall          (ctrl_xx_ex2_stall),
        .ctrl_xx_ex3_stall          (ctrl_xx_ex3_stall),
        .ctrl_xx_ex4_stall          (ctrl_xx_ex4_stall),
        .ctrl_xx_ex2_cancel         (ctrl_xx_ex2_cancel),
        .fpu_idu_ex1_stall          (fpu_idu_ex1_stall),
        .fpu_rtu_ex1_cmplt          (fpu_rtu_ex1_cmplt),
        .fpu_rtu_wb_vld             (fpu_rtu_wb_vld),
        .fpu_rtu_wb_src             (fpu_rtu_wb_src),
        .fpu_had_busy               (fpu_had_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: occupancy of EX2..EX4, one write-back port granted to
    // the oldest requester. A stage is stuck when its result wanted the port
    // and did not get it, or when it must move into a stuck stage.
    // -------------------------------------------------------------------------
    bit occ[2:4];

    always @(negedge clk) begin : model_cmp
        bit       sel, selg, req[2:4], mac3, grant, st1, st2, st3, st4;
        bit       n2, n3, n4;
        int       winner;
        logic [2:0] e_src;
        if (run_cmp) begin
            if (!cpurst_b) begin
                occ[2] = 0; occ[3] = 0; occ[4] = 0;
            end
            sel    = idu_fpu_ex1_inst_vld & idu_fpu_ex1_eu_sel[1];
            selg   = idu_fpu_ex1_gateclk_vld & idu_fpu_ex1_eu_sel[1];
            req[4] = occ[4];
            req[3] = fmau_fpu_ex3_result_vld;
            req[2] = occ[2] & fmau_fpu_ex2_special_cmplt & !rtu_fpu_ex2_cancel;
            winner = 0;
            for (int k = 2; k <= 4; k++) if (req[k]) winner = k;
            grant  = (winner != 0) && !rtu_fpu_wb_stall;
            e_src  = grant ? 3'(1 << (winner - 2)) : 3'b000;
            mac3   = occ[3] && !fmau_fpu_ex3_result_vld;
            st4    = occ[4] && !(grant && winner == 4);
            st3    = occ[3] && ((req[3] && !(grant && winner == 3)) || (mac3 && st4));
            st2    = occ[2] && ((req[2] && !(grant && winner == 2))
                                || (!fmau_fpu_ex2_special_cmplt && st3));
            st1    = fmau_fpu_ex1_denorm_stall || st2;

            chk("ex1_sel",      8'(ctrl_fmau_ex1_sel),      8'(sel));
            chk("ex1_sel_gate", 8'(ctrl_fmau_ex1_sel_gate), 8'(selg));
            chk("ex1_cmplt_dp", 8'(ctrl_xx_ex1_cmplt_dp),   8'(idu_fpu_ex1_inst_vld_dp));
            chk("ex1_stall",    8'(ctrl_xx_ex1_stall),      8'(st1));
            chk("ex2_stall",    8'(ctrl_xx_ex2_stall),      8'(st2));
            chk("ex3_stall",    8'(ctrl_xx_ex3_stall),      8'(st3));
            chk("ex4_stall",    8'(ctrl_xx_ex4_stall),      8'(st4));
            chk("ex2_cancel",   8'(ctrl_xx_ex2_cancel),     8'(rtu_fpu_ex2_cancel && occ[2]));
            chk("idu_stall",    8'(fpu_idu_ex1_stall),      8'(sel && st1));
            chk("ex1_cmplt",    8'(fpu_rtu_ex1_cmplt),
                8'(fmau_fpu_ex1_cmplt && !st2 && !rtu_xx_ex1_cancel));
            chk("wb_vld",       8'(fpu_rtu_wb_vld),         8'(grant));
            chk("wb_src",       8'(fpu_rtu_wb_src),         8'(e_src));
            chk("had_busy",     8'(fpu_had_busy),
                8'(occ[2] || occ[3] || occ[4] || fmau_fpu_id_reg_set));

            if (cpurst_b) begin
                if (rtu_fpu_ex2_cancel) n2 = 0;
                else if (st2)           n2 = occ[2];
                else                    n2 = sel && !rtu_xx_ex1_cancel && !st1;
                n3 = st3 ? occ[3] : (occ[2] && !rtu_fpu_ex2_cancel
                                     && !fmau_fpu_ex2_special_cmplt && !st2);
                n4 = st4 ? occ[4] : (mac3 && !st3);
                occ[2] = n2; occ[3] = n3; occ[4] = n4;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    task automatic idle();
        cp0_fpu_icg_en             = 1'b1;
        cp0_yy_clk_en              = 1'b1;
        pad_yy_icg_scan_en         = 1'b0;
        idu_fpu_ex1_inst_vld       = 1'b0;
        idu_fpu_ex1_gateclk_vld    = 1'b0;
        idu_fpu_ex1_inst_vld_dp    = 1'b0;
        idu_fpu_ex1_eu_sel         = 3'b000;
        rtu_xx_ex1_cancel          = 1'b0;
        rtu_fpu_ex2_cancel         = 1'b0;
        rtu_fpu_wb_stall           = 1'b0;
        fmau_fpu_ex1_cmplt         = 1'b0;
        fmau_fpu_ex1_denorm_stall  = 1'b0;
        fmau_fpu_id_reg_set        = 1'b0;
        fmau_fpu_ex2_special_cmplt = 1'b0;
        fmau_fpu_ex3_result_vld    = 1'b0;
    endtask

    task automatic issue();
        idu_fpu_ex1_inst_vld    = 1'b1;
        idu_fpu_ex1_gateclk_vld = 1'b1;
        idu_fpu_ex1_inst_vld_dp = 1'b1;
        idu_fpu_ex1_eu_sel      = 3'b010;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) next_cyc();
    endtask

    initial begin
        cpurst_b = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_wb_vld",  8'(fpu_rtu_wb_vld),    8'd0);
        chk("rst_busy",    8'(fpu_had_busy),      8'd0);
        chk("rst_ex4_stl", 8'(ctrl_xx_ex4_stall), 8'd0);
        @(posedge clk); #1;
        cpurst_b = 1'b1;

        // Non-mac op: written back from EX3 two cycles after issue.
        next_cyc(); issue();
        @(negedge clk);
        chk("A_sel", 8'(ctrl_fmau_ex1_sel), 8'd1);
        chk("A_ex1_stall", 8'(ctrl_xx_ex1_stall), 8'd0);
        next_cyc();
        @(negedge clk);
        chk("A_busy_c1", 8'(fpu_had_busy), 8'd1);
        chk("A_wbv_c1",  8'(fpu_rtu_wb_vld), 8'd0);
        next_cyc(); fmau_fpu_ex3_result_vld = 1'b1;
        @(negedge clk);
        chk("A_wbv_c2", 8'(fpu_rtu_wb_vld), 8'd1);
        chk("A_src_c2", 8'(fpu_rtu_wb_src), 8'h2);
        next_cyc();
        @(negedge clk);
        chk("A_busy_c3", 8'(fpu_had_busy), 8'd0);

        // Mac followed by a non-mac: EX4 wins, EX3 stalls one cycle.
        next_cyc(); issue();
        next_cyc(); issue();
        next_cyc();
        next_cyc(); fmau_fpu_ex3_result_vld = 1'b1;
        @(negedge clk);
        chk("B_src_c3",  8'(fpu_rtu_wb_src), 8'h4);
        chk("B_ex3s_c3", 8'(ctrl_xx_ex3_stall), 8'd1);
        next_cyc(); fmau_fpu_ex3_result_vld = 1'b1;
        @(negedge clk);
        chk("B_src_c4",  8'(fpu_rtu_wb_src), 8'h2);
        chk("B_ex3s_c4", 8'(ctrl_xx_ex3_stall), 8'd0);
        drain();

        // Denormal hold for one cycle, then re-issue.
        next_cyc(); issue(); fmau_fpu_ex1_denorm_stall = 1'b1;
        @(negedge clk);
        chk("C_ex1_stall", 8'(ctrl_xx_ex1_stall), 8'd1);
        chk("C_idu_stall", 8'(fpu_idu_ex1_stall), 8'd1);
        next_cyc(); issue(); fmau_fpu_id_reg_set = 1'b1; fmau_fpu_ex1_cmplt = 1'b1;
        @(negedge clk);
        chk("C_cmplt", 8'(fpu_rtu_ex1_cmplt), 8'd1);
        chk("C_ex1_stall_c1", 8'(ctrl_xx_ex1_stall), 8'd0);
        chk("C_busy", 8'(fpu_had_busy), 8'd1);
        drain();

        // Write-back port busy for 3 cycles with a mac chain in flight.
        next_cyc(); issue();
        next_cyc(); issue();
        next_cyc(); issue();
        for (int c = 0; c < 3; c++) begin
            next_cyc(); issue(); rtu_fpu_wb_stall = 1'b1;
            @(negedge clk);
            chk("D_ex4s", 8'(ctrl_xx_ex4_stall), 8'd1);
            chk("D_ex3s", 8'(ctrl_xx_ex3_stall), 8'd1);
            chk("D_ex2s", 8'(ctrl_xx_ex2_stall), 8'd1);
            chk("D_idus", 8'(fpu_idu_ex1_stall), 8'd1);
            chk("D_wbv",  8'(fpu_rtu_wb_vld), 8'd0);
        end
        next_cyc(); issue();
        @(negedge clk);
        chk("D_rel_idus", 8'(fpu_idu_ex1_stall), 8'd0);
        chk("D_rel_src",  8'(fpu_rtu_wb_src), 8'h4);
        for (int c = 0; c < 3; c++) begin
            next_cyc();
            @(negedge clk);
            chk("D_drain_src", 8'(fpu_rtu_wb_src), 8'h4);
        end
        drain();

        // EX2 flush while EX2 is stalled behind a blocked EX3 result.
        next_cyc(); issue();
        next_cyc(); issue();
        next_cyc(); fmau_fpu_ex3_result_vld = 1'b1; rtu_fpu_wb_stall = 1'b1;
        rtu_fpu_ex2_cancel = 1'b1;
        @(negedge clk);
        chk("E_ex2s",   8'(ctrl_xx_ex2_stall), 8'd1);
        chk("E_cancel", 8'(ctrl_xx_ex2_cancel), 8'd1);
        chk("E_wbv",    8'(fpu_rtu_wb_vld), 8'd0);
        next_cyc(); fmau_fpu_ex3_result_vld = 1'b1; rtu_fpu_ex2_cancel = 1'b1;
        @(negedge clk);
        chk("E_src",      8'(fpu_rtu_wb_src), 8'h2);
        chk("E_ex2_gone", 8'(ctrl_xx_ex2_cancel), 8'd0);
        next_cyc();
        @(negedge clk);
        chk("E_busy", 8'(fpu_had_busy), 8'd0);
        drain();

        // Reset while EX3 and EX4 both hold instructions.
        next_cyc(); issue();
        next_cyc(); issue();
        next_cyc();
        next_cyc();
        @(negedge clk);
        chk("F_busy_pre", 8'(fpu_had_busy), 8'd1);
        @(posedge clk); #3;
        idle();
        cpurst_b = 1'b0;
        #1;
        chk("F_busy", 8'(fpu_had_busy), 8'd0);
        chk("F_wbv",  8'(fpu_rtu_wb_vld), 8'd0);
        chk("F_ex4s", 8'(ctrl_xx_ex4_stall), 8'd0);
        @(negedge clk);
        @(posedge clk); #1;
        cpurst_b = 1'b1;

        // Randomized traffic, including one asynchronous reset pulse.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (i == 1502) cpurst_b = 1'b1;
            cp0_fpu_icg_en             = 1'($urandom_range(0, 1));
            cp0_yy_clk_en              = 1'b1;
            pad_yy_icg_scan_en         = ($urandom_range(0, 9) == 0);
            idu_fpu_ex1_inst_vld       = 1'($urandom_range(0, 1));
            idu_fpu_ex1_gateclk_vld    = idu_fpu_ex1_inst_vld | ($urandom_range(0, 3) == 0);
            idu_fpu_ex1_inst_vld_dp    = 1'($urandom_range(0, 1));
            idu_fpu_ex1_eu_sel         = 3'($urandom_range(0, 7));
            rtu_xx_ex1_cancel          = ($urandom_range(0, 11) == 0);
            rtu_fpu_ex2_cancel         = ($urandom_range(0, 11) == 0);
            rtu_fpu_wb_stall           = ($urandom_range(0, 3) == 0);
            fmau_fpu_ex1_cmplt         = 1'($urandom_range(0, 1));
            fmau_fpu_ex1_denorm_stall  = ($urandom_range(0, 6) == 0);
            fmau_fpu_id_reg_set        = ($urandom_range(0, 4) == 0);
            fmau_fpu_ex2_special_cmplt = ($urandom_range(0, 3) == 0);
            fmau_fpu_ex3_result_vld    = ($urandom_range(0, 4) < 2);
            if (i == 1500) begin
                #2;
                cpurst_b = 1'b0;
            end
        end

        @(posedge clk); #1;
        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pa_fpu_fmau_issue_ctrl.md
PA_FPU_FMAU_ISSUE_CTRL -- requirements
Module: pa_fpu_fmau_issue_ctrl

Interface
REQ-001 SHALL: forever_cpuclk  in  1  single clock; all state on posedge (through gated_clk_cell instances).
REQ-002 SHALL: cpurst_b  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: cp0_fpu_icg_en / cp0_yy_clk_en / pad_yy_icg_scan_en  in  1 each  ICG module_en / global_en / scan enable.
REQ-004 SHALL: idu_fpu_ex1_inst_vld, idu_fpu_ex1_gateclk_vld, idu_fpu_ex1_inst_vld_dp  in  1 each  EX1 valid, gate-clock valid, duplicate valid.
REQ-005 SHALL: idu_fpu_ex1_eu_sel  in  3  EU one-hot; bit[1] = FMAU.
REQ-006 SHALL: rtu_xx_ex1_cancel, rtu_fpu_ex2_cancel, rtu_fpu_wb_stall  in  1 each  EX1 cancel, EX2 flush, write-back port busy.
REQ-007 SHALL: fmau_fpu_ex1_cmplt, fmau_fpu_ex1_denorm_stall, fmau_fpu_id_reg_set, fmau_fpu_ex2_special_cmplt, fmau_fpu_ex3_result_vld  in  1 each  FMAU status.
REQ-008 SHALL: ctrl_fmau_ex1_sel, ctrl_fmau_ex1_sel_gate, ctrl_xx_ex1_cmplt_dp  out  1 each  FMAU issue select, gate select, dp completion qualifier.
REQ-009 SHALL: ctrl_xx_ex1_stall, ctrl_xx_ex2_stall, ctrl_xx_ex3_stall, ctrl_xx_ex4_stall, ctrl_xx_ex2_cancel  out  1 each  pipeline stall/cancel to FMAU.
REQ-010 SHALL: fpu_idu_ex1_stall, fpu_rtu_ex1_cmplt, fpu_rtu_wb_vld  out  1 each; fpu_rtu_wb_src  out  3  one-hot {EX4,EX3,EX2}; fpu_had_busy  out  1.

Function
REQ-011 SHALL: ctrl_fmau_ex1_sel = idu_fpu_ex1_inst_vld & eu_sel[1]; ctrl_fmau_ex1_sel_gate = idu_fpu_ex1_gateclk_vld & eu_sel[1]; ctrl_xx_ex1_cmplt_dp = idu_fpu_ex1_inst_vld_dp.
REQ-012 SHALL: keep mirror regs ex2_vld, ex3_vld, ex4_vld updated with exactly the FMAU rules: ex2: cancel->0, else !ex2_stall -> sel & !rtu_xx_ex1_cancel & !ex1_stall, else hold; ex3: !ex3_stall -> ex2_vld & !ex2_cancel & !special & !ex2_stall, else hold; ex4: !ex4_stall -> ex3_mac & !ex3_stall, else hold.
REQ-013 SHALL: ex3_mac = ex3_vld & !fmau_fpu_ex3_result_vld.
REQ-014 SHALL: write-back requesters: wb4 = ex4_vld; wb3 = fmau_fpu_ex3_result_vld; wb2 = ex2_vld & fmau_fpu_ex2_special_cmplt & !rtu_fpu_ex2_cancel; fixed priority EX4 > EX3 > EX2.
REQ-015 SHALL: fpu_rtu_wb_vld = (wb4|wb3|wb2) & !rtu_fpu_wb_stall; fpu_rtu_wb_src = one-hot winner, 3'b000 when fpu_rtu_wb_vld=0.
REQ-016 SHALL: ctrl_xx_ex4_stall = ex4_vld & rtu_fpu_wb_stall.
REQ-017 SHALL: ctrl_xx_ex3_stall = ex3_vld & ((wb3 & (rtu_fpu_wb_stall | wb4)) | (ex3_mac & ctrl_xx_ex4_stall)).
REQ-018 SHALL: ctrl_xx_ex2_stall = ex2_vld & ((wb2 & (rtu_fpu_wb_stall | wb4 | wb3)) | (!fmau_fpu_ex2_special_cmplt & ctrl_xx_ex3_stall)).
REQ-019 SHALL: ctrl_xx_ex1_stall = fmau_fpu_ex1_denorm_stall | ctrl_xx_ex2_stall; fpu_idu_ex1_stall = ctrl_fmau_ex1_sel & ctrl_xx_ex1_stall.
REQ-020 SHALL: ctrl_xx_ex2_cancel = rtu_fpu_ex2_cancel & ex2_vld.
REQ-021 SHALL: fpu_rtu_ex1_cmplt = fmau_fpu_ex1_cmplt & !ctrl_xx_ex2_stall & !rtu_xx_ex1_cancel.
REQ-022 SHALL: denormal: a single-cycle denorm_stall holds EX1; next cycle (id_reg_set=1) EX1 advances if no downstream stall; never two consecutive denorm stalls for one instruction.
REQ-023 SHALL: fpu_had_busy = ex2_vld | ex3_vld | ex4_vld | fmau_fpu_id_reg_set.
REQ-024 SHALL: ICG local_en: ex2 clk = sel_gate|ex2_vld; ex3 clk = ex2_vld|ex3_vld; ex4 clk = ex3_vld|ex4_vld.
REQ-025 SHALL: simultaneous cancel and stall at EX2: cancel wins, ex2_vld->0 next cycle.

Reset
REQ-026 SHALL: on cpurst_b=0 asynchronously clear ex2_vld/ex3_vld/ex4_vld; all stall, wb_vld, busy outputs then 0 with inputs idle; mid-operation reset drops all in-flight instructions with no write-back.

Verification
REQ-027 SHALL: non-mac FMAU op, no stalls -> sel=1 cycle0, wb_vld=1 src=3'b010 at cycle 2 (EX3).
REQ-028 SHALL: mac op then non-mac next cycle -> cycle3 wb4 wins src=3'b100, ctrl_xx_ex3_stall=1 one cycle, EX3 written cycle4 src=3'b010.
REQ-029 SHALL: denorm_stall=1 at cycle0 -> ctrl_xx_ex1_stall=1, fpu_idu_ex1_stall=1 cycle0; id_reg_set=1 cycle1, fpu_rtu_ex1_cmplt=1 cycle1.
REQ-030 SHALL: rtu_fpu_wb_stall=1 for 3 cycles with mac in EX4 -> ex4/ex3/ex2/ex1 stalls cascade, wb_vld=0, states held; release -> drain in priority order.
REQ-031 SHALL: rtu_fpu_ex2_cancel with ex2_vld=1 and ctrl_xx_ex2_stall=1 -> ex2_vld=0 next cycle, no write-back.
REQ-032 SHALL: cpurst_b low while ex3_vld=ex4_vld=1 -> all mirrors 0 immediately, fpu_had_busy=0, wb_vld=0.
